// File: rtl/udt_ctrl_master_if.sv
// AXI4-Lite control-bus bundle between udt_ctrl_master and the UDT
// ctrl_s_axi register slave.
//   master modport: drives AW/W/AR valids, addresses, data, strobes, B/R readies
//   slave  modport: drives AW/W/AR readies, B response, R data/response
interface udt_ctrl_master_if;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned RESP_W = 2;

    // write address channel
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    // write data channel
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    // write response channel
    logic [RESP_W-1:0] bresp;
    logic              bvalid;
    logic              bready;
    // read address channel
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    // read data channel
    logic [DATA_W-1:0] rdata;
    logic [RESP_W-1:0] rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport slave (
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );

endinterface

// File: rtl/udt_ctrl_master.sv
// Single-outstanding AXI4-Lite master for the UDT configuration register port.
// Accepts one register command at a time, runs the matching AXI4-Lite write or
// read, and returns the slave response. A per-transaction timeout aborts a hung
// slave and reports SLVERR with rsp_timeout_o set.
// Ports:
//   core_clk / core_rst : clock, asynchronous active-high reset
//   cmd_*               : command handshake (cmd_ready_o is combinational)
//   rsp_*               : response handshake, registered, held until rsp_ready_i
//   m_axi               : AXI4-Lite master bundle
//   err_cnt_o           : saturating count of non-OKAY responses delivered
module udt_ctrl_master #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned ERR_CNT_WIDTH  = 16
) (
    input  logic                     core_clk,
    input  logic                     core_rst,

    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic                     cmd_write_i,
    input  logic [31:0]              cmd_addr_i,
    input  logic [31:0]              cmd_wdata_i,
    input  logic [3:0]               cmd_wstrb_i,

    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [31:0]              rsp_rdata_o,
    output logic [1:0]               rsp_resp_o,
    output logic                     rsp_timeout_o,

    udt_ctrl_master_if.master        m_axi,

    output logic [ERR_CNT_WIDTH-1:0] err_cnt_o
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned RESP_W = 2;
    localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_REQ,
        S_WR_RESP,
        S_RD_REQ,
        S_RD_DATA,
        S_RSP
    } state_e;

    state_e                   state_q,     state_d;
    logic [ADDR_W-1:0]        awaddr_q,    awaddr_d;
    logic [DATA_W-1:0]        wdata_q,     wdata_d;
    logic [STRB_W-1:0]        wstrb_q,     wstrb_d;
    logic                     awvalid_q,   awvalid_d;
    logic                     wvalid_q,    wvalid_d;
    logic                     bready_q,    bready_d;
    logic [ADDR_W-1:0]        araddr_q,    araddr_d;
    logic                     arvalid_q,   arvalid_d;
    logic                     rready_q,    rready_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]        rsp_rdata_q, rsp_rdata_d;
    logic [RESP_W-1:0]        rsp_resp_q,  rsp_resp_d;
    logic                     rsp_tmo_q,   rsp_tmo_d;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q,   err_cnt_d;
    logic [TMO_W-1:0]         tmo_cnt_q,   tmo_cnt_d;

    logic tmo_hit;
    logic abort;
    logic aw_done;
    logic w_done;

    // Accept only in IDLE and never while reset is asserted.
    assign cmd_ready_o = (state_q == S_IDLE) && !core_rst;

    // Counter reaches TIMEOUT_CYCLES on this edge.
    assign tmo_hit = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

    // A channel is finished once its valid has dropped or it handshakes now.
    assign aw_done = !awvalid_q || m_axi.awready;
    assign w_done  = !wvalid_q  || m_axi.wready;

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        araddr_d    = araddr_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        rsp_tmo_d   = rsp_tmo_q;
        err_cnt_d   = err_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        abort       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid_i && cmd_ready_o) begin
                    tmo_cnt_d = '0;
                    if (cmd_write_i) begin
                        awaddr_d  = cmd_addr_i;
                        wdata_d   = cmd_wdata_i;
                        wstrb_d   = cmd_wstrb_i;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = S_WR_REQ;
                    end else begin
                        araddr_d  = cmd_addr_i;
                        arvalid_d = 1'b1;
                        state_d   = S_RD_REQ;
                    end
                end
            end

            S_WR_REQ: begin
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                if (awvalid_q && m_axi.awready) begin
                    awvalid_d = 1'b0;
                end
                if (wvalid_q && m_axi.wready) begin
                    wvalid_d = 1'b0;
                end
                if (aw_done && w_done) begin
                    bready_d = 1'b1;
                    state_d  = S_WR_RESP;
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end
            end

            S_WR_RESP: begin
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                if (m_axi.bvalid) begin
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_resp_d  = m_axi.bresp;
                    rsp_rdata_d = '0;
                    rsp_tmo_d   = 1'b0;
                    state_d     = S_RSP;
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end
            end

            S_RD_REQ: begin
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                if (m_axi.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RD_DATA;
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end
            end

            S_RD_DATA: begin
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                if (m_axi.rvalid) begin
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_resp_d  = m_axi.rresp;
                    rsp_rdata_d = m_axi.rdata;
                    rsp_tmo_d   = 1'b0;
                    state_d     = S_RSP;
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end
            end

            S_RSP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                    if ((rsp_resp_q != RESP_OKAY) &&
                        (err_cnt_q != {ERR_CNT_WIDTH{1'b1}})) begin
                        err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Hung-slave recovery: drop every handshake output and report SLVERR.
        if (abort) begin
            awvalid_d   = 1'b0;
            wvalid_d    = 1'b0;
            bready_d    = 1'b0;
            arvalid_d   = 1'b0;
            rready_d    = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_resp_d  = RESP_SLVERR;
            rsp_rdata_d = '0;
            rsp_tmo_d   = 1'b1;
            state_d     = S_RSP;
        end
    end

    // State and output registers.
    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            state_q     <= S_IDLE;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            araddr_q    <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
            rsp_tmo_q   <= 1'b0;
            err_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            araddr_q    <= araddr_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            rsp_tmo_q   <= rsp_tmo_d;
            err_cnt_q   <= err_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

    assign m_axi.awaddr  = awaddr_q;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = wstrb_q;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.bready  = bready_q;
    assign m_axi.araddr  = araddr_q;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.rready  = rready_q;

    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_resp_o    = rsp_resp_q;
    assign rsp_timeout_o = rsp_tmo_q;
    assign err_cnt_o     = err_cnt_q;

endmodule

// File: tb/tb_udt_ctrl_master.sv
// Directed bench for udt_ctrl_master; the bench plays the AXI4-Lite slave and
// the command/response host. All checks happen on the falling clock edge.
module tb_udt_ctrl_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;
    logic [15:0] err_cnt;

    int tests_run    = 0;
    int tests_failed = 0;
    int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;

    udt_ctrl_master_if axi ();

    udt_ctrl_master #(
        .TIMEOUT_CYCLES (16),
        .ERR_CNT_WIDTH  (16)
    ) dut (
        .core_clk      (clk),
        .core_rst      (rst),
        .cmd_valid_i   (cmd_valid),
        .cmd_ready_o   (cmd_ready),
        .cmd_write_i   (cmd_write),
        .cmd_addr_i    (cmd_addr),
        .cmd_wdata_i   (cmd_wdata),
        .cmd_wstrb_i   (cmd_wstrb),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_rdata_o   (rsp_rdata),
        .rsp_resp_o    (rsp_resp),
        .rsp_timeout_o (rsp_timeout),
        .m_axi         (axi),
        .err_cnt_o     (err_cnt)
    );

    always #5 clk = ~clk;

    // Handshake counters, observed on the active edge.
    always @(posedge clk) begin
        if (axi.awvalid && axi.awready) aw_hs <= aw_hs + 1;
        if (axi.wvalid  && axi.wready)  w_hs  <= w_hs + 1;
        if (axi.bvalid  && axi.bready)  b_hs  <= b_hs + 1;
        if (axi.arvalid && axi.arready) ar_hs <= ar_hs + 1;
        if (axi.rvalid  && axi.rready)  r_hs  <= r_hs + 1;
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic send_cmd(input logic wr, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] s);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_wstrb = s;
    endtask

    task automatic test_reset();
        cyc();
        tests_run++;
        if (cmd_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_cmd_ready_in_rst: got %b want 0", cmd_ready);
        end
        rst = 1'b0;
        cyc();
        tests_run++;
        if (cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready);
        end
        tests_run++;
        if ({axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready, rsp_valid} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_handshakes: got %b want 000000",
                     {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready, rsp_valid});
        end
        tests_run++;
        if ({axi.awaddr, axi.wdata, axi.wstrb, axi.araddr, rsp_rdata, rsp_resp, rsp_timeout, err_cnt} !== '0) begin
            tests_failed++;
            $display("FAIL reset_data: awaddr %h wdata %h wstrb %h araddr %h rdata %h resp %b tmo %b err %0d want all 0",
                     axi.awaddr, axi.wdata, axi.wstrb, axi.araddr, rsp_rdata, rsp_resp, rsp_timeout, err_cnt);
        end
    endtask

    task automatic test_write_basic();
        int a0 = aw_hs;
        int w0 = w_hs;
        axi.awready = 1'b1;
        axi.wready  = 1'b1;
        send_cmd(1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF);
        tests_run++;
        if (cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL wr_accept: cmd_ready %b want 1", cmd_ready);
        end
        cyc(); // cycle 1
        cmd_valid = 1'b0;
        tests_run++;
        if ({axi.awvalid, axi.wvalid, rsp_valid} !== 3'b110) begin
            tests_failed++;
            $display("FAIL wr_c1_valids: aw/w/rsp %b want 110", {axi.awvalid, axi.wvalid, rsp_valid});
        end
        tests_run++;
        if ({axi.awaddr, axi.wdata, axi.wstrb} !== {32'h0000_0004, 32'hDEAD_BEEF, 4'hF}) begin
            tests_failed++;
            $display("FAIL wr_c1_payload: addr %h data %h strb %h want 00000004 deadbeef f",
                     axi.awaddr, axi.wdata, axi.wstrb);
        end
        cyc(); // cycle 2
        tests_run++;
        if ({axi.awvalid, axi.wvalid, axi.bready} !== 3'b001) begin
            tests_failed++;
            $display("FAIL wr_c2_bready: aw/w/b %b want 001", {axi.awvalid, axi.wvalid, axi.bready});
        end
        axi.bvalid = 1'b1;
        axi.bresp  = 2'b00;
        cyc(); // cycle 3
        axi.bvalid = 1'b0;
        tests_run++;
        if ({rsp_valid, rsp_resp, rsp_timeout, axi.bready} !== 5'b10000 || rsp_rdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL wr_c3_rsp: valid %b resp %b tmo %b bready %b rdata %h want 1 00 0 0 0",
                     rsp_valid, rsp_resp, rsp_timeout, axi.bready, rsp_rdata);
        end
        tests_run++;
        if ((aw_hs - a0) != 1 || (w_hs - w0) != 1) begin
            tests_failed++;
            $display("FAIL wr_hs_count: aw %0d w %0d want 1 1", aw_hs - a0, w_hs - w0);
        end
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        tests_run++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL wr_rsp_done: rsp_valid/cmd_ready %b want 01", {rsp_valid, cmd_ready});
        end
    endtask

    task automatic test_write_aw_delay();
        int a0 = aw_hs;
        int w0 = w_hs;
        logic [1:0] exp_aw_w [1:4] = '{2'b11, 2'b10, 2'b10, 2'b10};
        axi.awready = 1'b0;
        axi.wready  = 1'b1;
        send_cmd(1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF);
        for (int c = 1; c <= 4; c++) begin
            cyc();
            cmd_valid = 1'b0;
            tests_run++;
            if ({axi.awvalid, axi.wvalid} !== exp_aw_w[c]) begin
                tests_failed++;
                $display("FAIL awdly_c%0d_valids: aw/w %b want %b", c, {axi.awvalid, axi.wvalid}, exp_aw_w[c]);
            end
        end
        axi.awready = 1'b1;
        cyc(); // cycle 5
        axi.awready = 1'b0;
        tests_run++;
        if ({axi.awvalid, axi.wvalid, axi.bready} !== 3'b001) begin
            tests_failed++;
            $display("FAIL awdly_c5_bready: aw/w/b %b want 001", {axi.awvalid, axi.wvalid, axi.bready});
        end
        axi.bvalid = 1'b1;
        cyc(); // cycle 6
        axi.bvalid = 1'b0;
        tests_run++;
        if ({rsp_valid, rsp_resp, rsp_timeout} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL awdly_rsp: valid %b resp %b tmo %b want 1 00 0", rsp_valid, rsp_resp, rsp_timeout);
        end
        tests_run++;
        if ((aw_hs - a0) != 1 || (w_hs - w0) != 1) begin
            tests_failed++;
            $display("FAIL awdly_hs_count: aw %0d w %0d want 1 1", aw_hs - a0, w_hs - w0);
        end
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
    endtask

    task automatic test_read();
        int ar0 = ar_hs;
        int r0  = r_hs;
        axi.arready = 1'b1;
        send_cmd(1'b0, 32'h0000_0010, 32'h0, 4'h0);
        cyc(); // cycle 1
        cmd_valid = 1'b0;
        tests_run++;
        if ({axi.arvalid, axi.awvalid} !== 2'b10 || axi.araddr !== 32'h0000_0010) begin
            tests_failed++;
            $display("FAIL rd_c1_ar: arvalid %b awvalid %b araddr %h want 1 0 00000010",
                     axi.arvalid, axi.awvalid, axi.araddr);
        end
        for (int c = 2; c <= 5; c++) begin
            cyc();
            tests_run++;
            if ({axi.arvalid, axi.rready, rsp_valid} !== 3'b010) begin
                tests_failed++;
                $display("FAIL rd_c%0d_wait: ar/r/rsp %b want 010", c, {axi.arvalid, axi.rready, rsp_valid});
            end
        end
        cyc(); // cycle 6
        axi.rvalid = 1'b1;
        axi.rdata  = 32'h1234_5678;
        axi.rresp  = 2'b00;
        cyc(); // cycle 7
        axi.rvalid = 1'b0;
        tests_run++;
        if ({rsp_valid, rsp_resp, rsp_timeout, axi.rready} !== 5'b10000 || rsp_rdata !== 32'h1234_5678) begin
            tests_failed++;
            $display("FAIL rd_rsp: valid %b resp %b tmo %b rready %b rdata %h want 1 00 0 0 12345678",
                     rsp_valid, rsp_resp, rsp_timeout, axi.rready, rsp_rdata);
        end
        tests_run++;
        if ((ar_hs - ar0) != 1 || (r_hs - r0) != 1) begin
            tests_failed++;
            $display("FAIL rd_hs_count: ar %0d r %0d want 1 1", ar_hs - ar0, r_hs - r0);
        end
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        tests_run++;
        if (err_cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL rd_err_cnt: got %0d want 0", err_cnt);
        end
    endtask

    task automatic test_timeout();
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        send_cmd(1'b1, 32'h0000_0008, 32'h0000_0001, 4'hF);
        for (int c = 1; c <= 16; c++) begin
            cyc();
            cmd_valid = 1'b0;
            tests_run++;
            if ({axi.awvalid, axi.wvalid, rsp_valid} !== 3'b110) begin
                tests_failed++;
                $display("FAIL tmo_c%0d_held: aw/w/rsp %b want 110", c, {axi.awvalid, axi.wvalid, rsp_valid});
            end
        end
        cyc(); // cycle 17
        tests_run++;
        if ({axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready} !== 5'b0) begin
            tests_failed++;
            $display("FAIL tmo_drop: aw/w/b/ar/r %b want 00000",
                     {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready});
        end
        tests_run++;
        if ({rsp_valid, rsp_resp, rsp_timeout} !== 4'b1101 || rsp_rdata !== 32'h0 || err_cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL tmo_rsp: valid %b resp %b tmo %b rdata %h err %0d want 1 10 1 0 0",
                     rsp_valid, rsp_resp, rsp_timeout, rsp_rdata, err_cnt);
        end
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        tests_run++;
        if (err_cnt !== 16'd1 || rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL tmo_err_cnt: err %0d rsp_valid %b want 1 0", err_cnt, rsp_valid);
        end
    endtask

    task automatic test_rsp_backpressure();
        axi.arready = 1'b1;
        axi.awready = 1'b1;
        axi.wready  = 1'b1;
        send_cmd(1'b0, 32'h0000_0020, 32'h0, 4'h0);
        cyc(); // cycle 1
        cmd_valid = 1'b0;
        cyc(); // cycle 2
        axi.rvalid = 1'b1;
        axi.rdata  = 32'hA5A5_0001;
        axi.rresp  = 2'b10;
        cyc(); // cycle 3
        axi.rvalid = 1'b0;
        send_cmd(1'b1, 32'h0000_0030, 32'h0BAD_F00D, 4'h3);
        for (int c = 3; c <= 7; c++) begin
            tests_run++;
            if ({rsp_valid, rsp_resp, rsp_timeout, cmd_ready} !== 5'b11000 ||
                rsp_rdata !== 32'hA5A5_0001 || err_cnt !== 16'd1) begin
                tests_failed++;
                $display("FAIL bp_c%0d_hold: valid %b resp %b tmo %b cmd_ready %b rdata %h err %0d want 1 10 0 0 a5a50001 1",
                         c, rsp_valid, rsp_resp, rsp_timeout, cmd_ready, rsp_rdata, err_cnt);
            end
            if (c == 7) rsp_ready = 1'b1;
            else        cyc();
        end
        cyc(); // cycle 8
        rsp_ready = 1'b0;
        tests_run++;
        if ({rsp_valid, cmd_ready} !== 2'b01 || err_cnt !== 16'd2) begin
            tests_failed++;
            $display("FAIL bp_c8_accept: rsp_valid %b cmd_ready %b err %0d want 0 1 2", rsp_valid, cmd_ready, err_cnt);
        end
        cyc(); // cycle 9
        cmd_valid = 1'b0;
        tests_run++;
        if ({axi.awvalid, axi.wvalid} !== 2'b11 ||
            {axi.awaddr, axi.wdata, axi.wstrb} !== {32'h0000_0030, 32'h0BAD_F00D, 4'h3}) begin
            tests_failed++;
            $display("FAIL bp_queued_cmd: aw/w %b addr %h data %h strb %h want 11 00000030 0badf00d 3",
                     {axi.awvalid, axi.wvalid}, axi.awaddr, axi.wdata, axi.wstrb);
        end
        cyc(); // cycle 10
        axi.bvalid = 1'b1;
        axi.bresp  = 2'b00;
        cyc(); // cycle 11
        axi.bvalid = 1'b0;
        tests_run++;
        if ({rsp_valid, rsp_resp} !== 3'b100 || rsp_rdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL bp_queued_rsp: valid %b resp %b rdata %h want 1 00 0", rsp_valid, rsp_resp, rsp_rdata);
        end
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        tests_run++;
        if (err_cnt !== 16'd2) begin
            tests_failed++;
            $display("FAIL bp_err_okay: err %0d want 2", err_cnt);
        end
    endtask

    task automatic test_reset_midtxn();
        axi.awready = 1'b1;
        axi.wready  = 1'b1;
        send_cmd(1'b1, 32'h0000_0040, 32'h0000_0055, 4'hF);
        cyc(); // cycle 1
        cmd_valid = 1'b0;
        cyc(); // cycle 2, in WR_RESP
        tests_run++;
        if (axi.bready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstmid_bready: got %b want 1", axi.bready);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if ({axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready, rsp_valid, cmd_ready} !== 7'b0) begin
            tests_failed++;
            $display("FAIL rstmid_handshakes: got %b want 0000000",
                     {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready, rsp_valid, cmd_ready});
        end
        tests_run++;
        if ({axi.awaddr, axi.wdata, axi.wstrb, axi.araddr, rsp_rdata, rsp_resp, rsp_timeout, err_cnt} !== '0) begin
            tests_failed++;
            $display("FAIL rstmid_data: awaddr %h wdata %h wstrb %h araddr %h rdata %h resp %b tmo %b err %0d want all 0",
                     axi.awaddr, axi.wdata, axi.wstrb, axi.araddr, rsp_rdata, rsp_resp, rsp_timeout, err_cnt);
        end
        axi.bvalid = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
        axi.bvalid = 1'b0;
        cyc();
        tests_run++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL rstmid_no_rsp: rsp_valid/cmd_ready %b want 01", {rsp_valid, cmd_ready});
        end
        axi.arready = 1'b1;
        send_cmd(1'b0, 32'h0000_0010, 32'h0, 4'h0);
        cyc(); // cycle 1
        cmd_valid = 1'b0;
        tests_run++;
        if (axi.arvalid !== 1'b1 || axi.araddr !== 32'h0000_0010) begin
            tests_failed++;
            $display("FAIL rstmid_rd_ar: arvalid %b araddr %h want 1 00000010", axi.arvalid, axi.araddr);
        end
        cyc(); // cycle 2
        axi.rvalid = 1'b1;
        axi.rdata  = 32'hCAFE_F00D;
        axi.rresp  = 2'b00;
        cyc(); // cycle 3
        axi.rvalid = 1'b0;
        tests_run++;
        if ({rsp_valid, rsp_resp, rsp_timeout} !== 4'b1000 || rsp_rdata !== 32'hCAFE_F00D) begin
            tests_failed++;
            $display("FAIL rstmid_rd_rsp: valid %b resp %b tmo %b rdata %h want 1 00 0 cafef00d",
                     rsp_valid, rsp_resp, rsp_timeout, rsp_rdata);
        end
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        tests_run++;
        if ({rsp_valid, cmd_ready} !== 2'b01 || err_cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL rstmid_rd_done: rsp_valid %b cmd_ready %b err %0d want 0 1 0", rsp_valid, cmd_ready, err_cnt);
        end
    endtask

    initial begin
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_write   = 1'b0;
        cmd_addr    = 32'h0;
        cmd_wdata   = 32'h0;
        cmd_wstrb   = 4'h0;
        rsp_ready   = 1'b0;
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bresp   = 2'b00;
        axi.bvalid  = 1'b0;
        axi.arready = 1'b0;
        axi.rdata   = 32'h0;
        axi.rresp   = 2'b00;
        axi.rvalid  = 1'b0;
        cyc();

        test_reset();
        test_write_basic();
        test_write_aw_delay();
        test_read();
        test_timeout();
        test_rsp_backpressure();
        test_reset_midtxn();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/udt_ctrl_master.md
# udt_ctrl_master

AXI4-Lite master that turns single-beat register commands into control-bus transactions on the UDT configuration register port (the `ctrl_s_axi_*` slave). It sits between a host or sequencer and the UDT core. It issues one write or read at a time and returns the slave's response. A per-transaction timeout recovers from a hung slave.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1024: cycles allowed from command accept to response capture before the transaction is aborted.
- `ERR_CNT_WIDTH`, default 16: width of the saturating error counter.

Ports:
- Clock and reset: one clock, `core_clk`; reset `core_rst` is asynchronous and active-high.
- `core_clk`, in, 1: single clock for all logic.
- `core_rst`, in, 1: asynchronous, active-high reset.
- `cmd_valid`, in, 1: command present.
- `cmd_ready`, out, 1: block can accept a command.
- `cmd_write`, in, 1: 1 = write, 0 = read.
- `cmd_addr`, in, 32: register byte address.
- `cmd_wdata`, in, 32: write data.
- `cmd_wstrb`, in, 4: write byte enables.
- `rsp_valid`, out, 1: response present.
- `rsp_ready`, in, 1: response consumed.
- `rsp_rdata`, out, 32: read data (0 for writes).
- `rsp_resp`, out, 2: BRESP or RRESP, or 2'b10 on timeout.
- `rsp_timeout`, out, 1: response was generated by timeout.
- `m_axi_awaddr` out 32, `m_axi_awvalid` out 1, `m_axi_awready` in 1: write address channel.
- `m_axi_wdata` out 32, `m_axi_wstrb` out 4, `m_axi_wvalid` out 1, `m_axi_wready` in 1: write data channel.
- `m_axi_bresp` in 2, `m_axi_bvalid` in 1, `m_axi_bready` out 1: write response channel.
- `m_axi_araddr` out 32, `m_axi_arvalid` out 1, `m_axi_arready` in 1: read address channel.
- `m_axi_rdata` in 32, `m_axi_rresp` in 2, `m_axi_rvalid` in 1, `m_axi_rready` out 1: read data channel.
- `err_cnt`, out, `ERR_CNT_WIDTH`: saturating count of responses with `rsp_resp != 2'b00`.

## Operation
- States:
  - IDLE: `cmd_ready`=1.
  - WR_REQ: `awvalid`/`wvalid`.
  - WR_RESP: `bready`=1.
  - RD_REQ: `arvalid`.
  - RD_DATA: `rready`=1.
  - RSP: `rsp_valid`=1.
- IDLE transitions: on `cmd_valid & cmd_ready`, latch addr, wdata and wstrb, clear the timeout counter, then go to WR_REQ (write) or RD_REQ (read).
- WR_REQ:
  - `awvalid` and `wvalid` assert together.
  - Each channel deasserts independently on its own handshake, and never re-asserts within that transaction.
  - Go to WR_RESP once both handshakes have occurred, including when they complete in the same cycle.
- WR_RESP: on `bvalid & bready`, capture `bresp` and set `rsp_rdata`=0. Go to RSP.
- RD_REQ: on `arvalid & arready`, go to RD_DATA.
- RD_DATA: on `rvalid & rready`, capture `rdata` and `rresp`. Go to RSP.
- RSP:
  - Hold all `rsp_*` stable until `rsp_ready`, then go to IDLE.
  - `err_cnt` increments by one on the RSP handshake when `rsp_resp != 0`; it saturates at all-ones.
- Timeout:
  - The counter increments every cycle in WR_REQ, WR_RESP, RD_REQ and RD_DATA.
  - When it reaches `TIMEOUT_CYCLES`, all `m_axi_*valid`/`*ready` outputs deassert next cycle.
  - Then `rsp_resp`=2'b10, `rsp_timeout`=1, `rsp_rdata`=0, and the state goes to RSP.
  - An abort is a deliberate protocol break for hung-slave recovery only.
- Simultaneous events: a handshake in the same cycle the counter reaches `TIMEOUT_CYCLES` wins; no timeout is flagged.
- Only one outstanding transaction. AW/W/AR/R ids and bursts are not used.

## Timing
- All outputs are registered except `cmd_ready`, which is the IDLE decode gated by `!core_rst`.
- Reset values: every `m_axi_*valid`/`*ready` = 0; `rsp_valid` = 0; `rsp_rdata`, `rsp_resp`, `rsp_timeout`, `err_cnt` = 0; all address/data outputs = 0; state = IDLE.
- Reset mid-transaction: outputs take reset values immediately (asynchronous). No response is produced for the aborted command.
- Write latency with an always-ready slave and `bvalid` one cycle after the W handshake:
  - command accept at cycle 0;
  - AW/W valid at cycle 1;
  - `bvalid` at cycle 2;
  - `rsp_valid` at cycle 3.
- Read latency with an always-ready slave and `rvalid` one cycle after AR: `arvalid` at cycle 1, `rsp_valid` at cycle 3.
- Back-to-back: the next command can be accepted in the cycle after the RSP handshake.

## Test plan
- Write 0xDEADBEEF, strb 4'hF, to 0x0000_0004 with an always-ready slave -> AW/W valid at cycle 1, one handshake each; `rsp_valid` at cycle 3 with resp 00, rdata 0.
- Same write with `awready` delayed 3 cycles and `wready` immediate -> `wvalid` drops after cycle 1; `awvalid` held until cycle 4; exactly one handshake per channel; resp 00.
- Read 0x0000_0010, slave returns 0x12345678 with rresp 00 five cycles after AR -> `rsp_rdata`=0x12345678, `rsp_timeout`=0, `err_cnt` unchanged.
- `TIMEOUT_CYCLES`=16 and the slave never asserts `awready` -> valids drop after 16 cycles; `rsp_resp`=10, `rsp_timeout`=1, `err_cnt`=1.
- `rsp_ready` held low 4 cycles -> response stays stable and `cmd_ready`=0 throughout; a queued command is accepted the cycle after the handshake.
- `core_rst` pulsed while in WR_RESP -> all outputs at reset values in the same cycle, no `rsp_valid`; a fresh read after reset completes normally.
